// File: rtl/seg_scan4.sv
// seg_scan4 -- four-digit multiplexed 7-segment display scanner.
//
// Scans four BCD digits onto one shared segment bus. Each digit gets a slot of
// SCAN_DIV clocks. The first GUARD clocks of every slot keep all anodes off to
// stop ghosting between digits. All displayed data comes from a shadow copy of
// the inputs. The shadow is taken once per frame, at the start of slot 0, so a
// frame never shows a mix of old and new values.
//
// Optional feature: define SEG_BLINK_EN to enable per-digit blinking. A blink
// phase toggles every BLINK_FRAMES frames. While the phase is 1, every digit
// selected by blink_mask is fully dark. Without the macro, blink_mask is
// ignored and no blink logic is built.
//
// Parameters
//   SCAN_DIV     clk cycles per digit slot (4..65535)
//   GUARD        anode-off cycles at the start of each slot (< SCAN_DIV)
//   BLINK_FRAMES frames per blink half-period (1..255)
//
// Ports
//   clk          system clock, rising edge
//   nCR          asynchronous active-low reset
//   dig0..dig3   BCD digits, dig0 rightmost, dig3 leftmost
//   dp_in        decimal-point request, bit i = digit i
//   blank_lz     leading-zero blanking enable
//   blink_mask   per-digit blink select (used only with SEG_BLINK_EN)
//   seg          segment bus, active-high, bit0=a .. bit6=g
//   dp           decimal point, active-high
//   an           digit enables, active-low, one-hot-low
//   frame_start  one-cycle pulse while slot 0 begins with freshly loaded data

module seg_scan4 #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       nCR,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_in,
  input  logic       blank_lz,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          started;

  logic [15:0]   sh_digs;
  logic [3:0]    sh_dp;
  logic          sh_lz;

  logic          terminal;
  logic          frame_load;

  logic [3:0]    cur_digit;
  logic [3:0]    lz_blank;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic [3:0]    an_d;

  function automatic logic [6:0] decode7(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  assign terminal = (presc == PW'(SCAN_DIV - 1));

  // The reset state (index 0, prescaler 0) counts as a frame start. The first
  // edge after reset therefore loads the shadow and holds the position there,
  // so slot 0 then runs its full length with the new data.
  assign frame_load = !started || (terminal && (idx == 2'd3));

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      presc   <= '0;
      idx     <= 2'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (!started) begin
        presc <= '0;
      end else if (terminal) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      sh_digs     <= '0;
      sh_dp       <= '0;
      sh_lz       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_load;
      if (frame_load) begin
        sh_digs <= {dig3, dig2, dig1, dig0};
        sh_dp   <= dp_in;
        sh_lz   <= blank_lz;
      end
    end
  end

`ifdef SEG_BLINK_EN
  logic [3:0] sh_blink;
  logic [7:0] blink_cnt;
  logic       blink_phase;

  // The blink counter holds the position of the current frame within its
  // half-period. It does not advance on the reset-release load, so frame 0 is
  // the first frame of phase 0.
  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      sh_blink    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_load) begin
      sh_blink <= blink_mask;
      if (started) begin
        if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end
  end
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
`endif

  // A digit is blanked as a leading zero only when it is zero and every digit
  // to its left is blanked too. Digit 0 is always shown.
  always_comb begin
    cur_digit   = sh_digs[{idx, 2'b00} +: 4];
    lz_blank[3] = sh_lz && (sh_digs[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (sh_digs[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (sh_digs[7:4] == 4'd0);
    lz_blank[0] = 1'b0;
    seg_d       = lz_blank[idx] ? 7'h00 : decode7(cur_digit);
    dp_d        = sh_dp[idx];
`ifdef SEG_BLINK_EN
    if (blink_phase && sh_blink[idx]) begin
      seg_d = 7'h00;
      dp_d  = 1'b0;
    end
`endif
    an_d = (presc < PW'(GUARD)) ? 4'b1111 : ~(4'b0001 << idx);
  end

  always_ff @(posedge clk or negedge nCR) begin
    if (!nCR) begin
      seg <= 7'h00;
      dp  <= 1'b0;
      an  <= 4'b1111;
    end else begin
      seg <= seg_d;
      dp  <= dp_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4 -- self-checking bench for seg_scan4.
//
// Uses a small configuration: SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2. A frame is
// therefore 16 clocks long. The reference model works out the expected outputs
// from the number of clock edges since reset was released, together with the
// inputs captured at each frame boundary. It uses only the display rules and
// no internal state of the design. When SEG_BLINK_EN is defined, the blink
// expectations switch on to match.

module tb_seg_scan4;

  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  typedef struct packed {
    logic [15:0] digs;
    logic [3:0]  dpi;
    logic        lz;
    logic [3:0]  mask;
  } in_t;

  typedef struct packed {
    in_t         stim;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp;
  } vec_t;

  logic       clk = 1'b0;
  logic       nCR;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [3:0] blink_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_start;

  int   total = 0;
  int   bad   = 0;
  int   m     = 0;
  in_t  cur_in;
  in_t  model_sh;
  vec_t vecs [8];

  always #5 clk = ~clk;

  seg_scan4 #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .nCR(nCR),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_in(dp_in), .blank_lz(blank_lz), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  function automatic logic [6:0] ref_seg7(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (d > 4'd9) ? 7'h00 : t[d];
  endfunction

  function automatic in_t mk_in(input logic [15:0] digs, input logic [3:0] dpi,
                                input logic lz, input logic [3:0] mask);
    in_t s;
    s.digs = digs; s.dpi = dpi; s.lz = lz; s.mask = mask;
    return s;
  endfunction

  task automatic applyStimulus(input in_t s);
    cur_in     = s;
    dig0       = s.digs[3:0];
    dig1       = s.digs[7:4];
    dig2       = s.digs[11:8];
    dig3       = s.digs[15:12];
    dp_in      = s.dpi;
    blank_lz   = s.lz;
    blink_mask = s.mask;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (edge %0d): got %0h expected %0h", name, m, act, exp);
    end
  endtask

  // Advances one clock and compares every output with the model. The outputs
  // seen after edge m describe the cycle just before that edge. Edge 1 shows
  // the reset position. Edge m >= 2 shows frame position (m-2) mod FRAME.
  task automatic step();
    int         p, slot, k;
    logic [3:0] e_an, d;
    logic [6:0] e_seg;
    logic       e_dp, blank;
    @(posedge clk);
    #1;
    m++;
    if (m == 1) begin
      p = 0; k = 0;
    end else begin
      p = (m - 2) % FRAME; k = (m - 2) / FRAME;
    end
    slot  = p / SD;
    e_an  = (p % SD < GD) ? 4'hF : ~(4'b0001 << slot);
    d     = model_sh.digs[slot*4 +: 4];
    blank = (slot != 0) && model_sh.lz && ((model_sh.digs >> (slot * 4)) == 16'h0);
    e_seg = blank ? 7'h00 : ref_seg7(d);
    e_dp  = model_sh.dpi[slot];
`ifdef SEG_BLINK_EN
    if ((m >= 2) && ((k / BF) % 2 == 1) && model_sh.mask[slot]) begin
      e_seg = 7'h00;
      e_dp  = 1'b0;
    end
`else
    if (k < 0) e_dp = 1'b0;
`endif
    checkOutput("an", 32'(an), 32'(e_an));
    checkOutput("seg", 32'(seg), 32'(e_seg));
    checkOutput("dp", 32'(dp), 32'(e_dp));
    checkOutput("frame_start", 32'(frame_start), 32'((m - 1) % FRAME == 0));
    if ((m - 1) % FRAME == 0) model_sh = cur_in;
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_an"}, 32'(an), 32'hF);
    checkOutput({name, "_seg"}, 32'(seg), 32'h0);
    checkOutput({name, "_dp"}, 32'(dp), 32'h0);
    checkOutput({name, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  task automatic waitLoad();
    int n = 0;
    do begin
      step();
      n++;
    end while (((m - 1) % FRAME != 0) && (n < 2 * FRAME));
    if ((m - 1) % FRAME != 0) checkOutput("load_timeout", 32'(n), 32'(FRAME));
  endtask

  task automatic releaseReset();
    @(negedge clk);
    nCR      = 1'b1;
    m        = 0;
    model_sh = '0;
  endtask

  initial begin
    logic [3:0] an_seq [8];
    in_t        s;
    logic [7:0] blink_frames;

    vecs[0] = '{mk_in(16'h4321, 4'b0000, 1'b0, 4'h0), {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000};
    vecs[1] = '{mk_in(16'h0005, 4'b0000, 1'b1, 4'h0), {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0000};
    vecs[2] = '{mk_in(16'h0100, 4'b0000, 1'b1, 4'h0), {7'h00, 7'h06, 7'h3F, 7'h3F}, 4'b0000};
    vecs[3] = '{mk_in(16'hF98C, 4'b0101, 1'b0, 4'h0), {7'h00, 7'h6F, 7'h7F, 7'h00}, 4'b0101};
    vecs[4] = '{mk_in(16'h0070, 4'b1100, 1'b1, 4'h0), {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b1100};
    vecs[5] = '{mk_in(16'h0000, 4'b1111, 1'b0, 4'h0), {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};
    vecs[6] = '{mk_in(16'h0000, 4'b0000, 1'b1, 4'h0), {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    vecs[7] = '{mk_in(16'h8765, 4'b0010, 1'b1, 4'h0), {7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b0010};
    an_seq  = '{4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101};
`ifdef SEG_BLINK_EN
    blink_frames = 8'b1100_1100;
`else
    blink_frames = 8'b0000_0000;
`endif

    // Outputs must sit at reset values while nCR is low, with or without edges.
    nCR = 1'b0;
    applyStimulus(vecs[0].stim);
    #12;
    checkReset("reset_hold");
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset_clocked");

    // First edge after release loads the shadow and pulses frame_start.
    releaseReset();
    step();
    checkOutput("first_frame_start", 32'(frame_start), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput($sformatf("an_seq%0d", i), 32'(an), 32'(an_seq[i]));
    end

    // Table vectors: load each one, then check the middle of every slot.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].stim);
      waitLoad();
      for (int i = 0; i < FRAME; i++) begin
        int p, slot;
        step();
        p    = (m - 2) % FRAME;
        slot = p / SD;
        if (p % SD == 2) begin
          checkOutput($sformatf("vec%0d_seg%0d", v, slot), 32'(seg), 32'(vecs[v].exp_seg[slot*7 +: 7]));
          checkOutput($sformatf("vec%0d_dp%0d", v, slot), 32'(dp), 32'(vecs[v].exp_dp[slot]));
        end
      end
    end

    // dig0 changes 1 -> 7 during slot 2; slot 0 shows 7 only after the next load.
    applyStimulus(mk_in(16'h4321, 4'b0000, 1'b0, 4'h0));
    waitLoad();
    repeat (3) step();
    checkOutput("tear_slot0_old", 32'(seg), 32'h06);
    repeat (6) step();
    s = cur_in;
    s.digs[3:0] = 4'd7;
    applyStimulus(s);
    waitLoad();
    repeat (3) step();
    checkOutput("tear_slot0_new", 32'(seg), 32'h07);

    // Reset asserted in the middle of slot 2 takes effect before the next edge.
    for (int n = 0; n < 2 * FRAME; n++) begin
      step();
      if ((m - 2) % FRAME == 2 * SD + 2) break;
    end
    #2;
    nCR = 1'b0;
    #1;
    checkReset("midslot_reset");
    applyStimulus(mk_in(16'h4321, 4'b0000, 1'b0, 4'b0001));
    repeat (2) @(posedge clk);
    #1;
    checkReset("midslot_reset_held");
    releaseReset();
    step();
    checkOutput("rerelease_frame_start", 32'(frame_start), 32'h1);

    // Blink: digit 0 dark in frames 2,3,6,7 when blinking is built in.
    for (int i = 0; i < 8 * FRAME; i++) begin
      int p, k;
      step();
      p = (m - 2) % FRAME;
      k = (m - 2) / FRAME;
      if (p == 2)
        checkOutput($sformatf("blink_f%0d_d0", k), 32'(seg), blink_frames[k] ? 32'h00 : 32'h06);
      if (p == SD + 2)
        checkOutput($sformatf("blink_f%0d_d1", k), 32'(seg), 32'h5B);
    end

    // Random inputs, often changed mid-frame, checked against the model.
    for (int i = 0; i < 30 * FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [15:0] dg;
        for (int j = 0; j < 4; j++)
          dg[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        applyStimulus(mk_in(dg, 4'($urandom), 1'($urandom), 4'($urandom)));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan4.md
SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, legal range 4..65535.
REQ-002 The block SHALL have parameter GUARD, default 2: leading clk cycles of each slot with all anodes off (anti-ghosting), GUARD < SCAN_DIV.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 64: scan frames per blink half-period, legal range 1..255.
REQ-004 The block SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-005 The block SHALL have port nCR, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port dig0, input, 4: BCD digit, rightmost position.
REQ-007 The block SHALL have port dig1, input, 4: BCD digit.
REQ-008 The block SHALL have port dig2, input, 4: BCD digit.
REQ-009 The block SHALL have port dig3, input, 4: BCD digit, leftmost position.
REQ-010 The block SHALL have port dp_in, input, 4: decimal-point request per digit, bit i = digit i.
REQ-011 The block SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-012 The block SHALL have port blink_mask, input, 4: per-digit blink select.
REQ-013 The block SHALL have port seg, output, 7: shared segment bus, active-high, bit0=a .. bit6=g.
REQ-014 The block SHALL have port dp, output, 1: shared decimal point, active-high.
REQ-015 The block SHALL have port an, output, 4: digit enables, active-low, one-hot-low, bit i = digit i.
REQ-016 The block SHALL have port frame_start, output, 1: one-cycle pulse when slot 0 begins.

Function
REQ-017 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; its terminal count SHALL advance the 2-bit slot index 0->1->2->3->0.
REQ-018 On the index 3->0 transition, dig0..dig3, dp_in, blank_lz and blink_mask SHALL be captured into a shadow register; displayed data SHALL change only at frame boundaries (no tearing).
REQ-019 frame_start SHALL pulse in the same cycle the shadow register loads.
REQ-020 seg, dp and an SHALL be registered, with one cycle latency from the index/prescaler state to the outputs.
REQ-021 While prescaler < GUARD, an SHALL be 4'b1111; otherwise an SHALL equal ~(1<<index).
REQ-022 Decode SHALL give 0-9 as standard 7-segment patterns; codes 10-15 SHALL give seg=0 (blank).
REQ-023 With shadow blank_lz=1: digit3 SHALL be blanked if 0; digit2 if 0 and digit3 blanked; digit1 if 0 and digit2 blanked; digit0 SHALL never be blanked.
REQ-024 A blanked digit SHALL drive seg=0; its dp SHALL still follow dp_in.
REQ-025 Inputs changing mid-frame SHALL have no effect until the next shadow load.

Reset
REQ-026 While nCR=0, regardless of clk, the outputs SHALL be held at an=4'b1111, seg=0, dp=0, frame_start=0.
REQ-027 While nCR=0, prescaler, index, blink counter, blink phase and shadow register SHALL be held at 0.
REQ-028 After nCR deasserts, the first shadow load SHALL occur on the first clk edge (index 0, prescaler 0 treated as frame start), with frame_start=1 in that cycle.
REQ-029 Reset asserted mid-slot SHALL force the reset values immediately (asynchronously).

Configuration
REQ-030 With macro SEG_BLINK_EN defined, a frame counter SHALL toggle blink phase every BLINK_FRAMES frames, and in phase 1 every digit whose shadow blink_mask bit is set SHALL drive seg=0 and dp=0.
REQ-031 Without SEG_BLINK_EN, blink_mask SHALL be ignored, and no blink counter or phase logic SHALL be synthesised.

Verification
REQ-032 SCAN_DIV=4, GUARD=1, digits 1,2,3,4 -> an sequence 1111,1110,1110,1110,1111,1101,... and seg per digit 0x06,0x5B,0x4F,0x66.
REQ-033 blank_lz=1, dig3..0=0,0,0,5 -> digits 3,2,1 seg=0 and digit0 seg=0x6D; dig3..0=0,1,0,0 -> only digit3 blank.
REQ-034 dig0 changed 1->7 during slot 2 -> slot-0 seg stays 0x06 until next frame_start, then 0x07.
REQ-035 SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 seg=0 in frames 2,3,6,7; other digits unaffected.
REQ-036 nCR pulsed low mid-slot 2 -> an=1111, seg=0 same cycle; after release first frame_start on first edge, then slot 0 displays.
REQ-037 Input dig=4'hC -> seg=0 in that slot, dp=1 if dp_in bit set.
